// File: rtl/tl_link_bridge_if.sv
// TileLink Acquire/Grant link bundle: Acquire flows master->slave, Grant flows slave->master.
// No logic inside; pure signal grouping for one client link.
// Backpressure is plain valid/ready on each channel.
interface tl_link_bridge_if #(
    parameter int DATA_W       = 128,
    parameter int ADDR_BLOCK_W = 26,
    parameter int XACT_ID_W    = 2,
    parameter int BEAT_W       = 2,
    parameter int UNION_W      = 17
);
    logic                    acquire_valid;
    logic                    acquire_ready;
    logic [XACT_ID_W-1:0]    acquire_bits_client_xact_id;
    logic                    acquire_bits_is_builtin_type;
    logic [2:0]              acquire_bits_a_type;
    logic [ADDR_BLOCK_W-1:0] acquire_bits_addr_block;
    logic [BEAT_W-1:0]       acquire_bits_addr_beat;
    logic [UNION_W-1:0]      acquire_bits_union;
    logic [DATA_W-1:0]       acquire_bits_data;

    logic                    grant_valid;
    logic                    grant_ready;
    logic [XACT_ID_W-1:0]    grant_bits_client_xact_id;
    logic [0:0]              grant_bits_manager_xact_id;
    logic                    grant_bits_is_builtin_type;
    logic [3:0]              grant_bits_g_type;
    logic [BEAT_W-1:0]       grant_bits_addr_beat;
    logic [DATA_W-1:0]       grant_bits_data;

    // Client side of a link: issues Acquires, receives Grants.
    modport master (
        output acquire_valid, acquire_bits_client_xact_id, acquire_bits_is_builtin_type,
               acquire_bits_a_type, acquire_bits_addr_block, acquire_bits_addr_beat,
               acquire_bits_union, acquire_bits_data,
        input  acquire_ready,
        input  grant_valid, grant_bits_client_xact_id, grant_bits_manager_xact_id,
               grant_bits_is_builtin_type, grant_bits_g_type, grant_bits_addr_beat,
               grant_bits_data,
        output grant_ready
    );

    // Manager side of a link: receives Acquires, returns Grants.
    modport slave (
        input  acquire_valid, acquire_bits_client_xact_id, acquire_bits_is_builtin_type,
               acquire_bits_a_type, acquire_bits_addr_block, acquire_bits_addr_beat,
               acquire_bits_union, acquire_bits_data,
        output acquire_ready,
        output grant_valid, grant_bits_client_xact_id, grant_bits_manager_xact_id,
               grant_bits_is_builtin_type, grant_bits_g_type, grant_bits_addr_beat,
               grant_bits_data,
        input  grant_ready
    );
endinterface

// File: rtl/tl_link_bridge.sv
// Registered TileLink Acquire/Grant bridge with an outstanding-transaction tracker.
// Latency: 1 cycle through each FIFO, no combinational bypass.
// Backpressure: ready = !full from registered occupancy; Acquire heads stall on busy id or MAX_OUT.

// Generic synchronous FIFO, power-of-2 depth, registered occupancy.
// Latency: a push is visible at the head the following cycle.
// Backpressure: push_rdy is !full only; a full FIFO cannot push even if it pops this cycle.
module tl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    // Head reads as zero when empty so idle outputs are clean.
    assign pop_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap comes for free from the power-of-2 depth.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clock) begin
        if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module tl_link_bridge #(
    parameter int DATA_W       = 128,
    parameter int ADDR_BLOCK_W = 26,
    parameter int XACT_ID_W    = 2,
    parameter int BEAT_W       = 2,
    parameter int UNION_W      = 17,
    parameter int ACQ_DEPTH    = 4,
    parameter int GNT_DEPTH    = 4,
    parameter int MAX_OUT      = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    tl_link_bridge_if.slave              in_link,
    tl_link_bridge_if.master             out_link,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         idle,
    output logic                         err_unexpected_grant
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int NID   = 1 << XACT_ID_W;

    typedef struct packed {
        logic [XACT_ID_W-1:0]    client_xact_id;
        logic                    is_builtin_type;
        logic [2:0]              a_type;
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [BEAT_W-1:0]       addr_beat;
        logic [UNION_W-1:0]      union_bits;
        logic [DATA_W-1:0]       data;
    } acq_t;

    typedef struct packed {
        logic [XACT_ID_W-1:0] client_xact_id;
        logic [0:0]           manager_xact_id;
        logic                 is_builtin_type;
        logic [3:0]           g_type;
        logic [BEAT_W-1:0]    addr_beat;
        logic [DATA_W-1:0]    data;
    } gnt_t;

    acq_t              acq_in;
    acq_t              acq_head;
    logic              acq_head_vld;
    logic              acq_pop_rdy;
    gnt_t              gnt_in;
    gnt_t              gnt_head;
    logic              gnt_head_vld;

    logic [NID-1:0]    busy;
    logic [NID-1:0]    busy_nxt;
    logic [BEAT_W-1:0] acq_cnt;
    logic [BEAT_W-1:0] gnt_cnt;

    logic acq_first, acq_multi, acq_gate, acq_fire;
    logic gnt_last, gnt_multi, gnt_fire;
    logic open_xact, close_xact, unexp_grant;

    // ---------------- Acquire path: client -> link ----------------
    assign acq_in = {in_link.acquire_bits_client_xact_id, in_link.acquire_bits_is_builtin_type,
                     in_link.acquire_bits_a_type, in_link.acquire_bits_addr_block,
                     in_link.acquire_bits_addr_beat, in_link.acquire_bits_union,
                     in_link.acquire_bits_data};

    tl_fifo #(.W($bits(acq_t)), .DEPTH(ACQ_DEPTH)) u_acq_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (in_link.acquire_valid),
        .push_rdy (in_link.acquire_ready),
        .push_dat (acq_in),
        .pop_vld  (acq_head_vld),
        .pop_rdy  (acq_pop_rdy),
        .pop_dat  (acq_head)
    );

    // Only the first beat of a message opens a transaction, so only it is gated.
    assign acq_first   = (acq_cnt == '0);
    assign acq_multi   = acq_head.is_builtin_type && (acq_head.a_type == 3'd3);
    assign acq_gate    = acq_first &&
                         (busy[acq_head.client_xact_id] || (outstanding == OUT_W'(MAX_OUT)));
    assign acq_pop_rdy = out_link.acquire_ready && !acq_gate;
    assign acq_fire    = acq_head_vld && acq_pop_rdy;

    assign out_link.acquire_valid                = acq_head_vld && !acq_gate;
    assign out_link.acquire_bits_client_xact_id  = acq_head.client_xact_id;
    assign out_link.acquire_bits_is_builtin_type = acq_head.is_builtin_type;
    assign out_link.acquire_bits_a_type          = acq_head.a_type;
    assign out_link.acquire_bits_addr_block      = acq_head.addr_block;
    assign out_link.acquire_bits_addr_beat       = acq_head.addr_beat;
    assign out_link.acquire_bits_union           = acq_head.union_bits;
    assign out_link.acquire_bits_data            = acq_head.data;

    // ---------------- Grant path: link -> client ----------------
    assign gnt_in = {out_link.grant_bits_client_xact_id, out_link.grant_bits_manager_xact_id,
                     out_link.grant_bits_is_builtin_type, out_link.grant_bits_g_type,
                     out_link.grant_bits_addr_beat, out_link.grant_bits_data};

    tl_fifo #(.W($bits(gnt_t)), .DEPTH(GNT_DEPTH)) u_gnt_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (out_link.grant_valid),
        .push_rdy (out_link.grant_ready),
        .push_dat (gnt_in),
        .pop_vld  (gnt_head_vld),
        .pop_rdy  (in_link.grant_ready),
        .pop_dat  (gnt_head)
    );

    assign gnt_multi = !gnt_head.is_builtin_type || (gnt_head.g_type == 4'd4);
    assign gnt_last  = !gnt_multi || (gnt_cnt == '1);
    assign gnt_fire  = gnt_head_vld && in_link.grant_ready;

    assign in_link.grant_valid                = gnt_head_vld;
    assign in_link.grant_bits_client_xact_id  = gnt_head.client_xact_id;
    assign in_link.grant_bits_manager_xact_id = gnt_head.manager_xact_id;
    assign in_link.grant_bits_is_builtin_type = gnt_head.is_builtin_type;
    assign in_link.grant_bits_g_type          = gnt_head.g_type;
    assign in_link.grant_bits_addr_beat       = gnt_head.addr_beat;
    assign in_link.grant_bits_data            = gnt_head.data;

    // ---------------- Tracker ----------------
    assign open_xact   = acq_fire && acq_first;
    assign close_xact  = gnt_fire && gnt_last && busy[gnt_head.client_xact_id];
    assign unexp_grant = gnt_fire && gnt_last && !busy[gnt_head.client_xact_id];

    // Next busy set; an open and a close on different ids both take effect.
    always_comb begin
        busy_nxt = busy;
        if (close_xact) busy_nxt[gnt_head.client_xact_id] = 1'b0;
        if (open_xact)  busy_nxt[acq_head.client_xact_id] = 1'b1;
    end

    // Beat counters locate message boundaries; single-beat messages leave them at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acq_cnt <= '0;
            gnt_cnt <= '0;
        end else begin
            if (acq_fire && acq_multi) acq_cnt <= acq_cnt + 1'b1;
            if (gnt_fire && gnt_multi) gnt_cnt <= gnt_cnt + 1'b1;
        end
    end

    // Busy bits, open count and sticky error; count never underflows on a stray Grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy                 <= '0;
            outstanding          <= '0;
            err_unexpected_grant <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (open_xact && !close_xact)
                outstanding <= outstanding + OUT_W'(1);
            else if (close_xact && !open_xact)
                outstanding <= outstanding - OUT_W'(1);
            if (unexp_grant) err_unexpected_grant <= 1'b1;
        end
    end

    assign idle = !acq_head_vld && !gnt_head_vld && (outstanding == '0);
endmodule

// File: tb/tb_tl_link_bridge.sv
// Self-checking bench for tl_link_bridge: scoreboard on both channels, vector table, corner sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or at the falling edge.
// All waits are bounded and an expired bound counts as an error.
module tb_tl_link_bridge;
    localparam int DATA_W    = 128;
    localparam int AB_W      = 26;
    localparam int ID_W      = 2;
    localparam int BEAT_W    = 2;
    localparam int UNION_W   = 17;
    localparam int ACQ_DEPTH = 4;
    localparam int GNT_DEPTH = 4;
    localparam int MAX_OUT   = 2;
    localparam int OUT_W     = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [ID_W-1:0]    client_xact_id;
        logic               is_builtin_type;
        logic [2:0]         a_type;
        logic [AB_W-1:0]    addr_block;
        logic [BEAT_W-1:0]  addr_beat;
        logic [UNION_W-1:0] union_bits;
        logic [DATA_W-1:0]  data;
    } acq_t;

    typedef struct packed {
        logic [ID_W-1:0]   client_xact_id;
        logic [0:0]        manager_xact_id;
        logic              is_builtin_type;
        logic [3:0]        g_type;
        logic [BEAT_W-1:0] addr_beat;
        logic [DATA_W-1:0] data;
    } gnt_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            a_bi;
        logic [2:0]      a_type;
        logic            g_bi;
        logic [3:0]      g_type;
        int              a_beats;
        int              g_beats;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    tl_link_bridge_if #(.DATA_W(DATA_W), .ADDR_BLOCK_W(AB_W), .XACT_ID_W(ID_W),
                        .BEAT_W(BEAT_W), .UNION_W(UNION_W)) in_l ();
    tl_link_bridge_if #(.DATA_W(DATA_W), .ADDR_BLOCK_W(AB_W), .XACT_ID_W(ID_W),
                        .BEAT_W(BEAT_W), .UNION_W(UNION_W)) out_l ();

    logic [OUT_W-1:0] outstanding;
    logic             idle;
    logic             err_unexpected_grant;

    tl_link_bridge #(.DATA_W(DATA_W), .ADDR_BLOCK_W(AB_W), .XACT_ID_W(ID_W), .BEAT_W(BEAT_W),
                     .UNION_W(UNION_W), .ACQ_DEPTH(ACQ_DEPTH), .GNT_DEPTH(GNT_DEPTH),
                     .MAX_OUT(MAX_OUT)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .in_link              (in_l),
        .out_link             (out_l),
        .outstanding          (outstanding),
        .idle                 (idle),
        .err_unexpected_grant (err_unexpected_grant)
    );

    int   checks = 0;
    int   errors = 0;
    int   acq_out_n = 0;
    int   gnt_in_n = 0;
    acq_t acq_q[$];
    gnt_t gnt_q[$];
    acq_t mon_acq_got, mon_acq_exp;
    gnt_t mon_gnt_got, mon_gnt_exp;
    vec_t vecs[6];

    function automatic acq_t cur_in_acq();
        return {in_l.acquire_bits_client_xact_id, in_l.acquire_bits_is_builtin_type,
                in_l.acquire_bits_a_type, in_l.acquire_bits_addr_block,
                in_l.acquire_bits_addr_beat, in_l.acquire_bits_union, in_l.acquire_bits_data};
    endfunction

    function automatic acq_t cur_out_acq();
        return {out_l.acquire_bits_client_xact_id, out_l.acquire_bits_is_builtin_type,
                out_l.acquire_bits_a_type, out_l.acquire_bits_addr_block,
                out_l.acquire_bits_addr_beat, out_l.acquire_bits_union, out_l.acquire_bits_data};
    endfunction

    function automatic gnt_t cur_out_gnt();
        return {out_l.grant_bits_client_xact_id, out_l.grant_bits_manager_xact_id,
                out_l.grant_bits_is_builtin_type, out_l.grant_bits_g_type,
                out_l.grant_bits_addr_beat, out_l.grant_bits_data};
    endfunction

    function automatic gnt_t cur_in_gnt();
        return {in_l.grant_bits_client_xact_id, in_l.grant_bits_manager_xact_id,
                in_l.grant_bits_is_builtin_type, in_l.grant_bits_g_type,
                in_l.grant_bits_addr_beat, in_l.grant_bits_data};
    endfunction

    // Scoreboard: record accepted beats, compare emitted beats in order.
    always @(negedge clock) begin
        if (reset_n) begin
            if (in_l.acquire_valid && in_l.acquire_ready) acq_q.push_back(cur_in_acq());
            if (out_l.grant_valid && out_l.grant_ready) gnt_q.push_back(cur_out_gnt());
            if (out_l.acquire_valid && out_l.acquire_ready) begin
                mon_acq_got = cur_out_acq();
                acq_out_n++;
                checks++;
                if (acq_q.size() == 0) begin
                    errors++;
                    $display("FAIL acq_sb: got %h, nothing was pending", mon_acq_got);
                end else begin
                    mon_acq_exp = acq_q.pop_front();
                    if (mon_acq_got !== mon_acq_exp) begin
                        errors++;
                        $display("FAIL acq_sb: got %h required %h", mon_acq_got, mon_acq_exp);
                    end
                end
            end
            if (in_l.grant_valid && in_l.grant_ready) begin
                mon_gnt_got = cur_in_gnt();
                gnt_in_n++;
                checks++;
                if (gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_sb: got %h, nothing was pending", mon_gnt_got);
                end else begin
                    mon_gnt_exp = gnt_q.pop_front();
                    if (mon_gnt_got !== mon_gnt_exp) begin
                        errors++;
                        $display("FAIL gnt_sb: got %h required %h", mon_gnt_got, mon_gnt_exp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic acq_t mk_acq(input logic [ID_W-1:0] id, input logic bi,
                                    input logic [2:0] t, input int beat);
        acq_t a;
        a.client_xact_id  = id;
        a.is_builtin_type = bi;
        a.a_type          = t;
        a.addr_block      = AB_W'($urandom);
        a.addr_beat       = BEAT_W'(beat);
        a.union_bits      = UNION_W'($urandom);
        a.data            = {$urandom, $urandom, $urandom, $urandom};
        return a;
    endfunction

    function automatic gnt_t mk_gnt(input logic [ID_W-1:0] id, input logic bi,
                                    input logic [3:0] t, input int beat);
        gnt_t g;
        g.client_xact_id  = id;
        g.manager_xact_id = 1'($urandom);
        g.is_builtin_type = bi;
        g.g_type          = t;
        g.addr_beat       = BEAT_W'(beat);
        g.data            = {$urandom, $urandom, $urandom, $urandom};
        return g;
    endfunction

    task automatic drive_acq(input acq_t b);
        {in_l.acquire_bits_client_xact_id, in_l.acquire_bits_is_builtin_type,
         in_l.acquire_bits_a_type, in_l.acquire_bits_addr_block, in_l.acquire_bits_addr_beat,
         in_l.acquire_bits_union, in_l.acquire_bits_data} = b;
        in_l.acquire_valid = 1'b1;
    endtask

    task automatic drive_gnt(input gnt_t b);
        {out_l.grant_bits_client_xact_id, out_l.grant_bits_manager_xact_id,
         out_l.grant_bits_is_builtin_type, out_l.grant_bits_g_type,
         out_l.grant_bits_addr_beat, out_l.grant_bits_data} = b;
        out_l.grant_valid = 1'b1;
    endtask

    task automatic push_acq(input acq_t b);
        int n = 0;
        drive_acq(b);
        while (!in_l.acquire_ready && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL push_acq_timeout: in_acquire_ready %0b, required 1", in_l.acquire_ready);
        end else tick();
        in_l.acquire_valid = 1'b0;
    endtask

    task automatic push_gnt(input gnt_t b);
        int n = 0;
        drive_gnt(b);
        while (!out_l.grant_ready && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL push_gnt_timeout: out_grant_ready %0b, required 1", out_l.grant_ready);
        end else tick();
        out_l.grant_valid = 1'b0;
    endtask

    task automatic wait_acq_out(input int target);
        int n = 0;
        while (acq_out_n < target && n < 300) begin tick(); n++; end
        if (acq_out_n < target) begin
            checks++; errors++;
            $display("FAIL wait_acq_out: %0d beats seen, required %0d", acq_out_n, target);
        end
    endtask

    task automatic wait_gnt_in(input int target);
        int n = 0;
        while (gnt_in_n < target && n < 300) begin tick(); n++; end
        if (gnt_in_n < target) begin
            checks++; errors++;
            $display("FAIL wait_gnt_in: %0d beats seen, required %0d", gnt_in_n, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_acq_rdy"}, in_l.acquire_ready, 1);
        check({tag, "_out_gnt_rdy"}, out_l.grant_ready, 1);
        check({tag, "_out_acq_vld"}, out_l.acquire_valid, 0);
        check({tag, "_in_gnt_vld"}, in_l.grant_valid, 0);
        check({tag, "_idle"}, idle, 1);
        check({tag, "_outstanding"}, outstanding, 0);
        check({tag, "_err"}, err_unexpected_grant, 0);
        check({tag, "_acq_bits"}, |cur_out_acq(), 0);
        check({tag, "_gnt_bits"}, |cur_in_gnt(), 0);
    endtask

    // Hard stop in case something blocks outside the bounded waits.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_a, base_g;
        // id, acq builtin, a_type, grant builtin, g_type, acq beats, grant beats
        vecs[0] = '{2'd1, 1'b1, 3'd0, 1'b1, 4'd3, 1, 1};  // Get / single grant
        vecs[1] = '{2'd0, 1'b1, 3'd3, 1'b1, 4'd4, 4, 4};  // putBlock / getDataBlock
        vecs[2] = '{2'd2, 1'b1, 3'd1, 1'b1, 4'd4, 1, 4};  // getBlock / getDataBlock
        vecs[3] = '{2'd3, 1'b0, 3'd3, 1'b0, 4'd3, 1, 4};  // custom a_type 3 is single; custom grant is multi
        vecs[4] = '{2'd1, 1'b1, 3'd3, 1'b1, 4'd0, 4, 1};  // putBlock / single ack
        vecs[5] = '{2'd0, 1'b1, 3'd2, 1'b1, 4'd5, 1, 1};  // single / builtin g_type 5 single

        in_l.acquire_valid  = 1'b0;
        in_l.grant_ready    = 1'b1;
        out_l.acquire_ready = 1'b0;
        out_l.grant_valid   = 1'b0;
        drive_acq('0); in_l.acquire_valid = 1'b0;
        drive_gnt('0); out_l.grant_valid = 1'b0;

        // Reset state.
        #2;
        check_reset_outputs("rst");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        tick();

        // Single-beat flow with cycle-exact latency.
        check("lat_pre_vld", out_l.acquire_valid, 0);
        push_acq(mk_acq(2'd1, 1'b1, 3'd0, 0));
        check("lat_acq_vld_n1", out_l.acquire_valid, 1);
        check("lat_outst_before_fire", outstanding, 0);
        check("lat_idle_busy", idle, 0);
        out_l.acquire_ready = 1'b1;
        tick();
        check("lat_outst_open", outstanding, 1);
        in_l.grant_ready = 1'b0;
        push_gnt(mk_gnt(2'd1, 1'b1, 4'd3, 0));
        check("lat_gnt_vld_n1", in_l.grant_valid, 1);
        in_l.grant_ready = 1'b1;
        tick();
        check("lat_outst_close", outstanding, 0);
        check("lat_idle", idle, 1);

        // Vector table: message lengths for each Acquire/Grant type.
        foreach (vecs[i]) begin
            base_a = acq_out_n;
            base_g = gnt_in_n;
            for (int b = 0; b < vecs[i].a_beats; b++)
                push_acq(mk_acq(vecs[i].id, vecs[i].a_bi, vecs[i].a_type, b));
            wait_acq_out(base_a + vecs[i].a_beats);
            check($sformatf("vec%0d_outst_open", i), outstanding, 1);
            for (int b = 0; b < vecs[i].g_beats; b++)
                push_gnt(mk_gnt(vecs[i].id, vecs[i].g_bi, vecs[i].g_type, b));
            wait_gnt_in(base_g + vecs[i].g_beats);
            check($sformatf("vec%0d_outst_close", i), outstanding, 0);
            check($sformatf("vec%0d_err", i), err_unexpected_grant, 0);
            check($sformatf("vec%0d_idle", i), idle, 1);
        end

        // Id reuse: second Get on id 2 waits for the id 2 Grant.
        in_l.grant_ready = 1'b0;
        push_acq(mk_acq(2'd2, 1'b1, 3'd0, 0));
        push_acq(mk_acq(2'd2, 1'b1, 3'd0, 0));
        tick();
        check("reuse_stall_vld", out_l.acquire_valid, 0);
        check("reuse_outst", outstanding, 1);
        push_gnt(mk_gnt(2'd2, 1'b1, 4'd3, 0));
        check("reuse_still_stalled", out_l.acquire_valid, 0);
        in_l.grant_ready = 1'b1;
        tick();
        check("reuse_gate_free", out_l.acquire_valid, 1);
        check("reuse_outst_closed", outstanding, 0);
        tick();
        check("reuse_reissued", outstanding, 1);
        base_g = gnt_in_n;
        push_gnt(mk_gnt(2'd2, 1'b1, 4'd3, 0));
        wait_gnt_in(base_g + 1);
        check("reuse_final_outst", outstanding, 0);

        // Limit: MAX_OUT=2, third open held until the first close.
        push_acq(mk_acq(2'd0, 1'b1, 3'd0, 0));
        push_acq(mk_acq(2'd1, 1'b1, 3'd0, 0));
        push_acq(mk_acq(2'd2, 1'b1, 3'd0, 0));
        tick();
        check("limit_outst", outstanding, 2);
        check("limit_held", out_l.acquire_valid, 0);
        push_gnt(mk_gnt(2'd0, 1'b1, 4'd3, 0));
        check("limit_held_pre_close", out_l.acquire_valid, 0);
        tick();
        check("limit_freed", out_l.acquire_valid, 1);
        check("limit_outst_after_close", outstanding, 1);
        tick();
        check("limit_third_open", outstanding, 2);
        base_g = gnt_in_n;
        push_gnt(mk_gnt(2'd1, 1'b1, 4'd3, 0));
        push_gnt(mk_gnt(2'd2, 1'b1, 4'd3, 0));
        wait_gnt_in(base_g + 2);
        check("limit_drained", outstanding, 0);
        check("limit_idle", idle, 1);

        // Acquire FIFO full under backpressure.
        out_l.acquire_ready = 1'b0;
        base_a = acq_out_n;
        for (int b = 0; b < ACQ_DEPTH; b++) push_acq(mk_acq(2'd0, 1'b1, 3'd3, b));
        check("acq_full_rdy", in_l.acquire_ready, 0);
        check("acq_full_head_vld", out_l.acquire_valid, 1);
        drive_acq(mk_acq(2'd1, 1'b1, 3'd0, 0));
        tick();
        tick();
        check("acq_full_still", in_l.acquire_ready, 0);
        out_l.acquire_ready = 1'b1;
        push_acq(cur_in_acq());
        wait_acq_out(base_a + ACQ_DEPTH + 1);
        check("acq_full_outst", outstanding, 2);

        // Grant FIFO full under backpressure.
        in_l.grant_ready = 1'b0;
        base_g = gnt_in_n;
        for (int b = 0; b < GNT_DEPTH; b++) push_gnt(mk_gnt(2'd0, 1'b1, 4'd4, b));
        check("gnt_full_rdy", out_l.grant_ready, 0);
        check("gnt_full_head_vld", in_l.grant_valid, 1);
        drive_gnt(mk_gnt(2'd1, 1'b1, 4'd3, 0));
        tick();
        tick();
        check("gnt_full_still", out_l.grant_ready, 0);
        in_l.grant_ready = 1'b1;
        push_gnt(cur_out_gnt());
        wait_gnt_in(base_g + GNT_DEPTH + 1);
        check("gnt_full_outst", outstanding, 0);
        check("gnt_full_err", err_unexpected_grant, 0);
        check("gnt_full_idle", idle, 1);

        // Unexpected Grant: forwarded, flagged, count untouched.
        base_g = gnt_in_n;
        push_gnt(mk_gnt(2'd3, 1'b1, 4'd3, 0));
        wait_gnt_in(base_g + 1);
        check("unexp_err", err_unexpected_grant, 1);
        check("unexp_outst", outstanding, 0);

        // Reset in the middle of a putBlock.
        push_acq(mk_acq(2'd0, 1'b1, 3'd3, 0));
        push_acq(mk_acq(2'd0, 1'b1, 3'd3, 1));
        tick();
        check("mid_outst", outstanding, 1);
        drive_acq(mk_acq(2'd0, 1'b1, 3'd3, 2));
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_l.acquire_valid = 1'b0;
        repeat (2) @(posedge clock);
        acq_q.delete();
        gnt_q.delete();
        @(negedge clock) reset_n = 1'b1;
        tick();
        base_a = acq_out_n;
        push_acq(mk_acq(2'd1, 1'b1, 3'd0, 0));
        wait_acq_out(base_a + 1);
        check("post_rst_open", outstanding, 1);
        base_g = gnt_in_n;
        push_gnt(mk_gnt(2'd1, 1'b1, 4'd3, 0));
        wait_gnt_in(base_g + 1);
        check("post_rst_close", outstanding, 0);
        check("post_rst_err", err_unexpected_grant, 0);

        repeat (3) tick();
        check("sb_acq_empty", acq_q.size(), 0);
        check("sb_gnt_empty", gnt_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
